// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add mantissa product,
// round-to-nearest-even, flush-to-zero on subnormal inputs and outputs.
module fp_mul_seq #(
   parameter int unsigned RADIX_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] c
);

   localparam int unsigned ITERS = 24 / RADIX_BITS;
   localparam int unsigned CNT_W = $clog2(ITERS);
   localparam int unsigned PW    = 48;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM} state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       mcand_q, mcand_d;
   logic [23:0]         mplier_q, mplier_d;
   logic [PW-1:0]       prod_q, prod_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic signed [9:0]   exp_q, exp_d;
   logic                sign_q, sign_d;
   logic                nan_q, nan_d;
   logic                inf_q, inf_d;
   logic                zero_q, zero_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [31:0]         c_q, c_d;

   // operand decode
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

   // iteration and normalisation intermediates
   logic [PW-1:0]     partial;
   logic [22:0]       mant, mant_r;
   logic              guard, sticky, inc;
   logic [23:0]       rnd;
   logic signed [9:0] e1, e2;
   logic [31:0]       norm_res;

   // Decode operand classes and mantissas with implicit leading one
   always_comb begin
      ea     = a[30:23];
      eb     = b[30:23];
      ma     = (ea != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
      mb     = (eb != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
      nan_a  = (ea == 8'hFF) && (a[22:0] != 23'd0);
      nan_b  = (eb == 8'hFF) && (b[22:0] != 23'd0);
      inf_a  = (ea == 8'hFF) && (a[22:0] == 23'd0);
      inf_b  = (eb == 8'hFF) && (b[22:0] == 23'd0);
      zero_a = (ea == 8'd0);
      zero_b = (eb == 8'd0);
   end

   // One radix digit of the multiplier times the multiplicand
   always_comb begin
      partial = '0;
      for (int i = 0; i < int'(RADIX_BITS); i++) begin
         if (mplier_q[i]) partial = partial + (mcand_q << i);
      end
   end

   // Normalise, round to nearest even, and resolve special results
   always_comb begin
      if (prod_q[47]) begin
         mant   = prod_q[46:24];
         guard  = prod_q[23];
         sticky = |prod_q[22:0];
         e1     = exp_q + 10'sd1;
      end else begin
         mant   = prod_q[45:23];
         guard  = prod_q[22];
         sticky = |prod_q[21:0];
         e1     = exp_q;
      end
      inc = guard & (sticky | mant[0]);
      rnd = {1'b0, mant} + 24'(inc);
      if (rnd[23]) begin
         mant_r = 23'd0;
         e2     = e1 + 10'sd1;
      end else begin
         mant_r = rnd[22:0];
         e2     = e1;
      end
      if (nan_q)                 norm_res = 32'h7FC00000;
      else if (inf_q)            norm_res = {sign_q, 8'hFF, 23'd0};
      else if (zero_q)           norm_res = {sign_q, 31'd0};
      else if (e2 >= 10'sd255)   norm_res = {sign_q, 8'hFF, 23'd0};
      else if (e2 <= 10'sd0)     norm_res = {sign_q, 31'd0};
      else                       norm_res = {sign_q, e2[7:0], mant_r};
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      nan_d    = nan_q;
      inf_d    = inf_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      c_d      = c_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = {24'd0, ma};
               mplier_d = mb;
               prod_d   = '0;
               cnt_d    = '0;
               exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
               sign_d   = a[31] ^ b[31];
               nan_d    = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
               inf_d    = (inf_a | inf_b) & ~(nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a));
               zero_d   = zero_a | zero_b;
               busy_d   = 1'b1;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            prod_d   = prod_q + partial;
            mcand_d  = mcand_q << RADIX_BITS;
            mplier_d = mplier_q >> RADIX_BITS;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_NORM;
         end
         S_NORM: begin
            c_d     = norm_res;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         c_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         c_q      <= c_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign c    = c_q;

endmodule
